mips_multicycle_ctrl: RTL

//  Main control FSM for the multicycle MIPS core. Sequences fetch/decode/execute/

---
 rtl/mips_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Main control FSM of the multicycle MIPS core; sequences
//               fetch/decode/execute/memory/writeback and drives datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] pc_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTEX    = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ITEX    = 4'd9,
        ST_JUMP    = 4'd10,
        ST_JR      = 4'd11,
        ST_ILLEGAL = 4'd12,
        ST_IDLE    = 4'd13
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    // The exception vector feeds the PC directly, so it must be word aligned.
    generate
        if (EXC_VECTOR[1:0] != 2'b00) begin : g_exc_vector_misaligned
            $error("EXC_VECTOR must be word aligned");
        end
    endgenerate

    state_t r_state;
    state_t w_next;

    logic w_is_lw;
    logic w_is_mem;
    logic w_is_rtype;
    logic w_is_branch;
    logic w_is_itype;
    logic w_is_jump;
    logic w_is_zext;

    assign w_is_lw     = (opcode == c_OP_LW);
    assign w_is_mem    = w_is_lw || (opcode == c_OP_SW);
    assign w_is_rtype  = (opcode == c_OP_RTYPE);
    assign w_is_branch = (opcode == c_OP_BEQ) || (opcode == c_OP_BNE);
    assign w_is_itype  = (opcode == c_OP_ADDI) || (opcode == c_OP_SLTI) ||
                         (opcode == c_OP_ANDI) || (opcode == c_OP_ORI);
    assign w_is_jump   = (opcode == c_OP_J) || (opcode == c_OP_JAL);
    assign w_is_zext   = (opcode == c_OP_ANDI) || (opcode == c_OP_ORI);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_is_mem)                             w_next = ST_MEMADR;
                else if (w_is_rtype && funct == c_FN_JR)  w_next = ST_JR;
                else if (w_is_rtype)                      w_next = ST_RTEX;
                else if (w_is_branch)                     w_next = ST_BRANCH;
                else if (w_is_itype)                      w_next = ST_ITEX;
                else if (w_is_jump)                       w_next = ST_JUMP;
                else                                      w_next = ST_ILLEGAL;
            end
            ST_MEMADR: w_next = w_is_lw ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTEX:   w_next = ST_ALUWB;
            ST_ITEX:   w_next = ST_ALUWB;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 3'd0;
        alu_op     = 2'd0;
        pc_src     = 3'd0;
        case (r_state)
            ST_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 3'd1;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            // PC+4 is already in the PC, so this adds the branch offset to it.
            ST_DECODE: alu_src_b = 3'd3;
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'd2;
            end
            ST_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            ST_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 2'd1;
            end
            ST_MEMWR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
            end
            ST_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            ST_ITEX: begin
                alu_src_a = 1'b1;
                alu_src_b = w_is_zext ? 3'd4 : 3'd2;
                alu_op    = 2'd3;
            end
            ST_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = w_is_rtype ? 2'd1 : 2'd0;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 3'd1;
                pc_we     = (opcode == c_OP_BNE) ? ~zero : zero;
            end
            ST_JUMP: begin
                pc_src = 3'd2;
                pc_we  = 1'b1;
                if (opcode == c_OP_JAL) begin
                    reg_we     = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
            end
            ST_JR: begin
                pc_src = 3'd3;
                pc_we  = 1'b1;
            end
            ST_ILLEGAL: begin
                pc_src = 3'd4;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire
